serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller that time-multiplexes one full-adder slice (two half-adder stages plus an OR) over WIDTH cycles to add two WIDTH-bit operands.
- Sits between a requester and the 1-bit half-adder datapath, and owns operand latching, bit sequencing, carry propagation and result handshake.
- Trades latency for area: one adder slice serves the whole word.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  reset, asynchronous and active-high.
- start_in  input  1  request to begin an add; sampled only when ready=1.
- A_in  input  WIDTH  operand A; sampled on the edge that accepts start_in.
- B_in  input  WIDTH  operand B; sampled on the edge that accepts start_in.
- ready  output  1  high in IDLE; a start is accepted only when this is high.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; SUM/CARRY are valid when it is high.
- SUM  output  WIDTH  result, LSB-first accumulated; holds until next accepted start.
- CARRY  output  1  carry out of MSB; holds until next accepted start.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All state is registered on the rising edge of clk.
- Reset values: state=IDLE, ready=1, busy=0, done=0, SUM=0, CARRY=0, internal carry=0, bit index=0, operand shift registers=0.
- States:
  - IDLE -> RUN when start_in=1. On that edge, latch A_in and B_in into shift registers, clear the carry and index, and clear SUM/CARRY to 0.
  - RUN: each edge processes bit `idx`.
    - Half-adder stage 1: s1 = a^b, c1 = a&b.
    - Half-adder stage 2: s = s1^cin, c2 = s1&cin.
    - Carry update: cout = c1|c2, registered as the new cin.
    - Write s into SUM[idx] (or shift in at the MSB; either is acceptable if the final order is correct). Increment idx.
  - RUN -> DONE on the edge that processes idx=WIDTH-1. On that same edge, CARRY takes cout and done goes to 1.
  - DONE -> IDLE unconditionally on the next edge. done returns to 0 and ready to 1.
- Latency: if the start is accepted on edge E0, bits are processed on E1..E_WIDTH and done is high during the cycle after E_WIDTH. Total is WIDTH+1 edges from accept to done.
- Throughput: the earliest next accept is one edge after DONE, i.e. one add per WIDTH+2 cycles.
- start_in is ignored while busy=1; no queuing and no error flag. A_in/B_in changes while busy have no effect.
- Arithmetic is unsigned and modulo 2^WIDTH; CARRY is the true carry out.
- Asserting rst mid-RUN or in DONE immediately forces reset values; any partial result is discarded and no done pulse is produced.
- Outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds port sub_in (input, 1), latched together with the operands on accept.
  - When sub_in=1: the B shift register is loaded with ~B_in and the initial carry is 1, so the block computes A-B.
  - CARRY=1 means no borrow (A>=B); CARRY=0 means borrow.
  - Latency is unchanged.
- Undefined: the sub_in port does not exist, and the block only adds.

Test Plan:
- After reset: ready=1, busy=0, done=0, SUM=0x00, CARRY=0. Then start with A=0x00, B=0x00 -> done exactly 9 edges after accept; SUM=0x00, CARRY=0.
- A=0xFF, B=0x01 (WIDTH=8) -> SUM=0x00, CARRY=1. Checks full carry ripple through all 8 bits.
- A=0xA5, B=0x5A -> SUM=0xFF, CARRY=0. Then start_in is held high continuously -> the next accept occurs on the edge after the done cycle, never during RUN.
- Start A=0x3C, B=0x0F, then pulse start_in with A=0x01, B=0x01 at cycle 4 -> the second request is ignored; the result is SUM=0x4B, CARRY=0.
- Assert rst at cycle 5 of an add of 0x80+0x80 -> outputs return to reset values at once, no done pulse. A fresh 0x80+0x80 then gives SUM=0x00, CARRY=1.
- With SERIAL_ADDER_SUB_EN: 0x10-0x01 -> SUM=0x0F, CARRY=1; 0x01-0x02 -> SUM=0xFF, CARRY=0.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder slice reused over WIDTH cycles, LSB first.
// Optional subtract mode (A-B) when SERIAL_ADDER_SUB_EN is defined.
module serial_adder_ctrl #(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_in,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               cin_q, cin_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;

    logic sub_sel;
    logic s1, c1, s, c2, cout;
    logic last_bit;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_sel = sub_in;
`else
    assign sub_sel = 1'b0;
`endif

    assign last_bit = (idx_q == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cin_q   <= cin_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start_in) state_d = ST_RUN;
            ST_RUN:  if (last_bit) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Single full-adder slice built from two half adders.
    always_comb begin
        s1   = a_q[0] ^ b_q[0];
        c1   = a_q[0] & b_q[0];
        s    = s1 ^ cin_q;
        c2   = s1 & cin_q;
        cout = c1 | c2;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        cin_d   = cin_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    a_d     = A_in;
                    b_d     = sub_sel ? ~B_in : B_in;
                    cin_d   = sub_sel;
                    idx_d   = '0;
                    sum_d   = '0;
                    carry_d = 1'b0;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cin_d = cout;
                // Shift in at the MSB; after WIDTH steps bit 0 lands at the LSB.
                sum_d = {s, sum_q[WIDTH-1:1]};
                idx_d = idx_q + CNT_W'(1);
                if (last_bit) carry_d = cout;
            end
            default: ;
        endcase
    end

    always_comb begin
        ready = (state_q == ST_IDLE);
        busy  = (state_q == ST_RUN) || (state_q == ST_DONE);
        done  = (state_q == ST_DONE);
    end

    assign SUM   = sum_q;
    assign CARRY = carry_q;

endmodule
